// File: rtl/phv_assembler.sv
// Re-forms the PHV from per-lane ALU results and hands it downstream with valid/ready.
// Lanes that never report are left at their original value once the collect timer expires.
module phv_assembler #(
    parameter int unsigned STAGE_ID   = 0,
    parameter int unsigned NUM_ALU    = 8,
    parameter int unsigned DATA_WIDTH = 48,
    parameter int unsigned META_WIDTH = 256,
    parameter int unsigned PHV_LEN    = NUM_ALU * DATA_WIDTH + META_WIDTH,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PHV_LEN-1:0]            phv_in,
    input  logic                          phv_in_valid,
    output logic                          phv_in_ready,
    input  logic [NUM_ALU*DATA_WIDTH-1:0] alu_data_in,
    input  logic [NUM_ALU-1:0]            alu_valid_in,
    output logic [PHV_LEN-1:0]            phv_out,
    output logic                          phv_out_valid,
    input  logic                          phv_out_ready,
    output logic                          err_timeout,
    output logic [15:0]                   drop_cnt
);

    typedef enum logic [1:0] {StIdle, StCollect, StOutput} state_e;

    localparam logic [7:0] TimeoutVal = 8'(TIMEOUT);

    state_e               state_q, state_d;
    logic [PHV_LEN-1:0]   phv_q, phv_d;
    logic [NUM_ALU-1:0]   mask_q, mask_d;
    logic [7:0]           timer_q, timer_d;
    logic                 err_q, err_d;
    logic [15:0]          drop_q;
    logic                 mask_full;
    logic                 timeout_hit;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (phv_in_valid) state_d = mask_full ? StOutput : StCollect;
            StCollect: if (mask_full || timeout_hit) state_d = StOutput;
            StOutput:  if (phv_out_ready) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        phv_in_ready  = (state_q == StIdle);
        phv_out_valid = (state_q == StOutput);
    end

    // Lane capture: the first valid per lane wins, later ones are ignored via the mask.
    always_comb begin
        phv_d   = phv_q;
        mask_d  = mask_q;
        timer_d = timer_q;
        unique case (state_q)
            StIdle: begin
                if (phv_in_valid) begin
                    phv_d   = phv_in;
                    mask_d  = '0;
                    timer_d = '0;
                    for (int i = 0; i < NUM_ALU; i++) begin
                        if (alu_valid_in[i]) begin
                            phv_d[META_WIDTH + i*DATA_WIDTH +: DATA_WIDTH] =
                                alu_data_in[i*DATA_WIDTH +: DATA_WIDTH];
                            mask_d[i] = 1'b1;
                        end
                    end
                end
            end
            StCollect: begin
                timer_d = timer_q + 8'd1;
                for (int i = 0; i < NUM_ALU; i++) begin
                    if (alu_valid_in[i] && !mask_q[i]) begin
                        phv_d[META_WIDTH + i*DATA_WIDTH +: DATA_WIDTH] =
                            alu_data_in[i*DATA_WIDTH +: DATA_WIDTH];
                        mask_d[i] = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Completion in the same cycle as expiry takes priority, so no error then.
    always_comb begin
        mask_full   = &mask_d;
        timeout_hit = (state_q == StCollect) && !mask_full && (timer_d == TimeoutVal);
        err_d       = timeout_hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phv_q   <= '0;
            mask_q  <= '0;
            timer_q <= '0;
            err_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            phv_q   <= phv_d;
            mask_q  <= mask_d;
            timer_q <= timer_d;
            err_q   <= err_d;
            if (phv_in_valid && !phv_in_ready && (drop_q != 16'hFFFF)) begin
                drop_q <= drop_q + 16'd1;
            end
        end
    end

    assign phv_out     = phv_q;
    assign err_timeout = err_q;
    assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_phv_assembler.sv
// Randomized bench for phv_assembler; each PHV's expected result and output cycle are
// derived from per-lane arrival times rather than by stepping a state machine.
module tb_phv_assembler;

    localparam int NA = 4;
    localparam int DW = 8;
    localparam int MW = 16;
    localparam int TO = 6;
    localparam int PL = NA * DW + MW;
    localparam int NEVER = 99;

    logic              clk = 1'b0;
    logic              rst;
    logic [PL-1:0]     phv_in;
    logic              phv_in_valid;
    logic              phv_in_ready;
    logic [NA*DW-1:0]  alu_data_in;
    logic [NA-1:0]     alu_valid_in;
    logic [PL-1:0]     phv_out;
    logic              phv_out_valid;
    logic              phv_out_ready;
    logic              err_timeout;
    logic [15:0]       drop_cnt;

    phv_assembler #(
        .STAGE_ID   (0),
        .NUM_ALU    (NA),
        .DATA_WIDTH (DW),
        .META_WIDTH (MW),
        .TIMEOUT    (TO)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .phv_in        (phv_in),
        .phv_in_valid  (phv_in_valid),
        .phv_in_ready  (phv_in_ready),
        .alu_data_in   (alu_data_in),
        .alu_valid_in  (alu_valid_in),
        .phv_out       (phv_out),
        .phv_out_valid (phv_out_valid),
        .phv_out_ready (phv_out_ready),
        .err_timeout   (err_timeout),
        .drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_bad = 0;
    int          exp_drop = 0;
    // Cycle (relative to phv_in_valid) at which each lane's ALU result appears, and an
    // optional later repeat carrying junk that must be ignored.
    int          d_arr   [NA];
    int          rep_arr [NA];
    logic [DW-1:0] new_arr [NA];
    logic [PL-1:0] orig;
    bit          drop_en;
    int          bp;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        phv_in_valid  = 1'b0;
        phv_in        = '0;
        alu_valid_in  = '0;
        alu_data_in   = '0;
        phv_out_ready = 1'b0;
    endtask

    task automatic drive_cycle(input int k, input bit first);
        phv_in_valid = first ? 1'b1 : (drop_en && ($urandom_range(0, 3) == 0));
        if (!first && phv_in_valid) exp_drop++;
        phv_in = first ? orig : PL'({$urandom(), $urandom()});
        for (int i = 0; i < NA; i++) begin
            alu_valid_in[i] = (d_arr[i] == k) || (rep_arr[i] == k);
            alu_data_in[i*DW +: DW] = (d_arr[i] == k) ? new_arr[i] : DW'($urandom());
        end
    endtask

    task automatic run_txn();
        int            maxd;
        int            e_cyc;
        bit            exp_err;
        logic [PL-1:0] exp_phv;
        int            k;

        maxd = 0;
        foreach (d_arr[i]) if (d_arr[i] > maxd) maxd = d_arr[i];
        exp_err = (maxd > TO);
        e_cyc   = exp_err ? TO + 1 : ((maxd == 0) ? 1 : maxd + 1);
        exp_phv = orig;
        for (int i = 0; i < NA; i++) begin
            if (d_arr[i] <= TO) exp_phv[MW + i*DW +: DW] = new_arr[i];
        end

        check_eq("idle_ready", 64'(phv_in_ready), 64'd1);
        k = 0;
        for (int c = 0; c < e_cyc; c++) begin
            drive_cycle(k, c == 0);
            phv_out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
            k++;
            if (k < e_cyc) begin
                check_eq("early_valid", 64'(phv_out_valid), 64'd0);
                check_eq("busy_ready", 64'(phv_in_ready), 64'd0);
            end
        end
        for (int j = 0; j <= bp; j++) begin
            check_eq("out_valid", 64'(phv_out_valid), 64'd1);
            check_eq("out_phv", 64'(phv_out), 64'(exp_phv));
            check_eq("out_err", 64'(err_timeout), 64'((j == 0) && exp_err));
            check_eq("out_ready", 64'(phv_in_ready), 64'd0);
            drive_cycle(k, 1'b0);
            phv_out_ready = (j == bp);
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        check_eq("post_valid", 64'(phv_out_valid), 64'd0);
        check_eq("post_ready", 64'(phv_in_ready), 64'd1);
        check_eq("post_err", 64'(err_timeout), 64'd0);
        check_eq("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
        idle_inputs();
    endtask

    task automatic setup(input int d0, input int d1, input int d2, input int d3,
                         input int r0, input int bp_in, input bit den);
        orig = PL'({$urandom(), $urandom()});
        d_arr[0] = d0; d_arr[1] = d1; d_arr[2] = d2; d_arr[3] = d3;
        foreach (rep_arr[i]) rep_arr[i] = -1;
        rep_arr[0] = r0;
        foreach (new_arr[i]) new_arr[i] = DW'($urandom());
        bp      = bp_in;
        drop_en = den;
    endtask

    task automatic gap_noise(input int n);
        for (int c = 0; c < n; c++) begin
            alu_valid_in = NA'($urandom());
            alu_data_in  = (NA*DW)'($urandom());
            @(posedge clk);
            @(negedge clk);
            check_eq("gap_valid", 64'(phv_out_valid), 64'd0);
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        check_eq("rst_valid", 64'(phv_out_valid), 64'd0);
        check_eq("rst_phv", 64'(phv_out), 64'd0);
        check_eq("rst_err", 64'(err_timeout), 64'd0);
        check_eq("rst_drop", 64'(drop_cnt), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        setup(2, 2, 2, 2, -1, 0, 1'b0);         run_txn();
        setup(1, 2, 2, 5, 3, 0, 1'b0);          run_txn();
        setup(1, 1, NEVER, 2, -1, 0, 1'b0);     run_txn();
        setup(1, 1, 1, 1, -1, 5, 1'b1);         run_txn();
        setup(0, 0, 0, 0, -1, 0, 1'b0);         run_txn();
        setup(TO, 1, 1, 1, -1, 1, 1'b0);        run_txn();

        // Reset in the middle of collection with two lanes filled
        setup(1, 2, NEVER, NEVER, -1, 0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drive_cycle(k, k == 0);
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        check_eq("mid_rst_valid", 64'(phv_out_valid), 64'd0);
        check_eq("mid_rst_phv", 64'(phv_out), 64'd0);
        check_eq("mid_rst_err", 64'(err_timeout), 64'd0);
        check_eq("mid_rst_drop", 64'(drop_cnt), 64'd0);
        check_eq("mid_rst_ready", 64'(phv_in_ready), 64'd1);
        idle_inputs();
        exp_drop = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        setup(NEVER, NEVER, 1, 2, -1, 0, 1'b0); run_txn();

        // Randomized PHVs
        for (int t = 0; t < 40; t++) begin
            orig = PL'({$urandom(), $urandom()});
            foreach (d_arr[i]) begin
                d_arr[i]   = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, TO + 2);
                rep_arr[i] = ($urandom_range(0, 2) == 0 && d_arr[i] != NEVER)
                             ? d_arr[i] + 1 + $urandom_range(0, 3) : -1;
                new_arr[i] = DW'($urandom());
            end
            bp      = $urandom_range(0, 4);
            drop_en = 1'($urandom_range(0, 1));
            run_txn();
            gap_noise($urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
